// File: rtl/cont_disp_gate_if.sv
// Display-gate bus: upstream display vector, trigger controls and gated outputs.
// Parameters must match the cont_disp_gate instance this bus is connected to.
interface cont_disp_gate_if #(
  parameter int unsigned DISPBITS = 32,
  parameter int unsigned CNTW     = 16
);
  logic [DISPBITS-1:0] DispValIn;
  logic                TrigIn;
  logic                StopIn;
  logic [CNTW-1:0]     HoldOff;
  logic [CNTW-1:0]     MaxCycles;
  logic [DISPBITS-1:0] DispEn;
  logic                Active;
  logic                Done;
  logic                Changed;
  logic [CNTW-1:0]     ActiveCount;

  modport master (
    output DispValIn, TrigIn, StopIn, HoldOff, MaxCycles,
    input  DispEn, Active, Done, Changed, ActiveCount
  );

  modport slave (
    input  DispValIn, TrigIn, StopIn, HoldOff, MaxCycles,
    output DispEn, Active, Done, Changed, ActiveCount
  );
endinterface

// File: rtl/cont_disp_gate.sv
// Trigger / hold-off / bounded-window gate for the display-control vector.
// All outputs are registered; the window counter is shared by HOLD and ACTIVE.
module cont_disp_gate #(
  parameter int unsigned DISPBITS = 32,
  parameter int unsigned CNTW     = 16
) (
  input logic             Clk,
  input logic             Reset,
  cont_disp_gate_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  state_t              state_q, state_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [DISPBITS-1:0] disp_q, disp_d;
  logic                done_q, done_d;
  logic                changed_q, changed_d;
  logic [CNTW-1:0]     acnt_q, acnt_d;
  logic                val_nz;

  assign val_nz = |bus.DispValIn;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      disp_q    <= '0;
      done_q    <= 1'b0;
      changed_q <= 1'b0;
      acnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      disp_q    <= disp_d;
      done_q    <= done_d;
      changed_q <= changed_d;
      acnt_q    <= acnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    disp_d  = '0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!bus.StopIn && bus.TrigIn && val_nz) begin
          if (bus.HoldOff == '0) begin
            state_d = ACTIVE;
            cnt_d   = bus.MaxCycles;
            disp_d  = bus.DispValIn;
          end else begin
            state_d = HOLD;
            cnt_d   = bus.HoldOff;
          end
        end
      end

      HOLD: begin
        if (bus.StopIn) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_ONE) begin
          state_d = ACTIVE;
          cnt_d   = bus.MaxCycles;
          disp_d  = bus.DispValIn;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ACTIVE: begin
        // A loaded count of zero means an unbounded window: never decrement.
        if (bus.StopIn || !val_nz) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          disp_d = bus.DispValIn;
          if (bus.TrigIn) begin
            cnt_d = bus.MaxCycles;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Only compare consecutive ACTIVE cycles, so window entry never pulses.
  always_comb begin
    changed_d = (state_q == ACTIVE) && (state_d == ACTIVE) && (disp_d != disp_q);
  end

  always_comb begin
    acnt_d = acnt_q;
    if (state_q == ACTIVE && acnt_q != '1) begin
      acnt_d = acnt_q + CNT_ONE;
    end
  end

  assign bus.DispEn      = disp_q;
  assign bus.Active      = (state_q == ACTIVE);
  assign bus.Done        = done_q;
  assign bus.Changed     = changed_q;
  assign bus.ActiveCount = acnt_q;

endmodule

// File: tb/tb_cont_disp_gate.sv
// Directed bench for cont_disp_gate: inputs driven 1ns after each rising edge,
// outputs checked in the same cycle; a second CNTW=4 instance covers saturation.
module tb_cont_disp_gate;

  logic Clk;
  logic Reset;
  int   checks;
  int   errors;

  cont_disp_gate_if #(.DISPBITS(32), .CNTW(16)) bus_a ();
  cont_disp_gate_if #(.DISPBITS(32), .CNTW(4))  bus_b ();

  cont_disp_gate #(.DISPBITS(32), .CNTW(16)) dut_a (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus_a.slave)
  );

  cont_disp_gate #(.DISPBITS(32), .CNTW(4)) dut_b (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus_b.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic act, input logic [31:0] disp,
                         input logic done, input logic chg);
    check({tag, ".Active"},  64'(bus_a.Active),  64'(act));
    check({tag, ".DispEn"},  64'(bus_a.DispEn),  64'(disp));
    check({tag, ".Done"},    64'(bus_a.Done),    64'(done));
    check({tag, ".Changed"}, 64'(bus_a.Changed), 64'(chg));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset  = 1'b1;
    bus_a.DispValIn = '0; bus_a.TrigIn = 1'b0; bus_a.StopIn = 1'b0;
    bus_a.HoldOff   = '0; bus_a.MaxCycles = '0;
    bus_b.DispValIn = '0; bus_b.TrigIn = 1'b0; bus_b.StopIn = 1'b0;
    bus_b.HoldOff   = '0; bus_b.MaxCycles = '0;
    tick();
    tick();
    Reset = 1'b0;
    tick();
    check_a("reset", 1'b0, 32'h0, 1'b0, 1'b0);
    check("reset.ActiveCount", 64'(bus_a.ActiveCount), 64'h0);

    // Basic window: HoldOff=0, MaxCycles=5
    bus_a.DispValIn = 32'h3; bus_a.HoldOff = 16'd0; bus_a.MaxCycles = 16'd5;
    bus_a.TrigIn = 1'b1;
    tick();
    bus_a.TrigIn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_a($sformatf("basic.c%0d", i), 1'b1, 32'h3, 1'b0, 1'b0);
      tick();
    end
    check_a("basic.end", 1'b0, 32'h0, 1'b1, 1'b0);
    check("basic.ActiveCount", 64'(bus_a.ActiveCount), 64'd5);
    tick();
    check("basic.DoneOnce", 64'(bus_a.Done), 64'h0);

    // Hold-off: HoldOff=3, MaxCycles=2
    bus_a.HoldOff = 16'd3; bus_a.MaxCycles = 16'd2;
    bus_a.TrigIn = 1'b1;
    tick();
    bus_a.TrigIn = 1'b0;
    bus_a.HoldOff = 16'd9;
    for (int i = 0; i < 3; i++) begin
      check_a($sformatf("hold.h%0d", i), 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
    end
    check_a("hold.a0", 1'b1, 32'h3, 1'b0, 1'b0);
    tick();
    check_a("hold.a1", 1'b1, 32'h3, 1'b0, 1'b0);
    tick();
    check_a("hold.end", 1'b0, 32'h0, 1'b1, 1'b0);
    check("hold.ActiveCount", 64'(bus_a.ActiveCount), 64'd7);

    // Live update and extension: MaxCycles=4, value 1 -> 6, retrigger
    bus_a.HoldOff = 16'd0; bus_a.MaxCycles = 16'd4; bus_a.DispValIn = 32'h1;
    bus_a.TrigIn = 1'b1;
    tick();
    bus_a.TrigIn = 1'b0;
    check_a("live.c1", 1'b1, 32'h1, 1'b0, 1'b0);
    tick();
    check_a("live.c2", 1'b1, 32'h1, 1'b0, 1'b0);
    bus_a.DispValIn = 32'h6;
    tick();
    check_a("live.c3", 1'b1, 32'h6, 1'b0, 1'b1);
    bus_a.TrigIn = 1'b1;
    tick();
    bus_a.TrigIn = 1'b0;
    for (int i = 4; i <= 7; i++) begin
      check_a($sformatf("live.c%0d", i), 1'b1, 32'h6, 1'b0, 1'b0);
      tick();
    end
    check_a("live.end", 1'b0, 32'h0, 1'b1, 1'b0);
    check("live.ActiveCount", 64'(bus_a.ActiveCount), 64'd14);

    // Stop during an unbounded window
    bus_a.MaxCycles = 16'd0;
    bus_a.TrigIn = 1'b1;
    tick();
    bus_a.TrigIn = 1'b0;
    tick(); tick(); tick();
    check_a("unb.c4", 1'b1, 32'h6, 1'b0, 1'b0);
    bus_a.StopIn = 1'b1;
    tick();
    bus_a.StopIn = 1'b0;
    check_a("stop", 1'b0, 32'h0, 1'b0, 1'b0);

    // Trigger with zero value is ignored
    bus_a.DispValIn = 32'h0;
    bus_a.TrigIn = 1'b1;
    tick();
    bus_a.TrigIn = 1'b0;
    check_a("zerotrig", 1'b0, 32'h0, 1'b0, 1'b0);

    // Value drops to zero mid-window
    bus_a.DispValIn = 32'h7;
    bus_a.TrigIn = 1'b1;
    tick();
    bus_a.TrigIn = 1'b0;
    check_a("zdrop.act", 1'b1, 32'h7, 1'b0, 1'b0);
    bus_a.DispValIn = 32'h0;
    tick();
    check_a("zdrop.idle", 1'b0, 32'h0, 1'b0, 1'b0);

    // Stop beats trigger in IDLE
    bus_a.DispValIn = 32'h7;
    bus_a.TrigIn = 1'b1; bus_a.StopIn = 1'b1;
    tick();
    bus_a.TrigIn = 1'b0; bus_a.StopIn = 1'b0;
    check_a("stoptrig", 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check_a("stoptrig.n", 1'b0, 32'h0, 1'b0, 1'b0);

    // Expiry beats reload; same-cycle trigger not re-accepted
    bus_a.MaxCycles = 16'd2;
    bus_a.TrigIn = 1'b1;
    tick();
    bus_a.TrigIn = 1'b0;
    tick();
    check_a("exp.last", 1'b1, 32'h7, 1'b0, 1'b0);
    bus_a.TrigIn = 1'b1;
    tick();
    bus_a.TrigIn = 1'b0;
    check_a("exp.end", 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    check_a("exp.noretrig", 1'b0, 32'h0, 1'b0, 1'b0);

    // Saturation on the CNTW=4 instance
    bus_b.DispValIn = 32'h1; bus_b.MaxCycles = 4'd0; bus_b.HoldOff = 4'd0;
    bus_b.TrigIn = 1'b1;
    tick();
    bus_b.TrigIn = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    check("sat.c14", 64'(bus_b.ActiveCount), 64'hE);
    for (int i = 0; i < 6; i++) tick();
    check("sat.c20", 64'(bus_b.ActiveCount), 64'hF);
    check("sat.Active", 64'(bus_b.Active), 64'h1);

    // Asynchronous reset mid-window
    bus_a.DispValIn = 32'h5; bus_a.MaxCycles = 16'd0;
    bus_a.TrigIn = 1'b1;
    tick();
    bus_a.TrigIn = 1'b0;
    check_a("rst.pre", 1'b1, 32'h5, 1'b0, 1'b0);
    #2;
    Reset = 1'b1;
    #1;
    check_a("rst.async", 1'b0, 32'h0, 1'b0, 1'b0);
    check("rst.ActiveCount", 64'(bus_a.ActiveCount), 64'h0);
    check("rst.b.Active", 64'(bus_b.Active), 64'h0);
    tick();
    Reset = 1'b0;
    tick();
    check_a("rst.rel1", 1'b0, 32'h0, 1'b0, 1'b0);
    bus_a.TrigIn = 1'b1;
    tick();
    bus_a.TrigIn = 1'b0;
    check_a("rst.retrig", 1'b1, 32'h5, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
